// File: rtl/remote_mem_pkg.sv
// rtl/remote_mem_pkg.sv - shared state/kind types and byte-protocol constants for remote_mem
package remote_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_HDR,
    CMD_ADDR,
    CMD_DATA,
    RSP_READ,
    RSP_CAP,
    ACK
  } state_t;

  typedef enum logic [1:0] {
    KIND_GET,
    KIND_PUT,
    KIND_BAD
  } kind_t;

  localparam logic [7:0] RM_OP_GET = 8'h00;
  localparam logic [7:0] RM_OP_PUT = 8'h01;
  localparam logic [7:0] RM_STS_OK = 8'h00;

  // Byte count of a beat of the given (already clamped) log2 size.
  function automatic logic [3:0] size_bytes(input logic [2:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/remote_mem_if.sv
// rtl/remote_mem_if.sv - TileLink-style A/D channel bundle with master/slave views
interface remote_mem_if #(
  parameter int DATA_BYTES = 8,
  parameter int SOURCE_W   = 4
);
  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_size;
  logic [SOURCE_W-1:0]     a_source;
  logic [63:0]             a_address;
  logic [DATA_BYTES-1:0]   a_mask;
  logic [DATA_BYTES*8-1:0] a_data;

  logic                    d_valid;
  logic                    d_ready;
  logic [2:0]              d_opcode;
  logic [2:0]              d_size;
  logic [SOURCE_W-1:0]     d_source;
  logic [DATA_BYTES*8-1:0] d_data;

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_size, d_source, d_data
  );
endinterface

// File: rtl/isa.vh
// rtl/isa.vh - TileLink A/D channel opcode encodings
`ifndef ISA_VH
`define ISA_VH
`define TL_A_PUT_FULL_DATA    3'd0
`define TL_A_PUT_PARTIAL_DATA 3'd1
`define TL_A_GET              3'd4
`define TL_D_ACCESS_ACK       3'd0
`define TL_D_ACCESS_ACK_DATA  3'd1
`endif

// File: rtl/remote_mem_ser.sv
// rtl/remote_mem_ser.sv - LSB-first byte serialiser feeding the command FIFO
module remote_mem_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] vec,
  input  logic [3:0]  cnt,
  input  logic        full,
  output logic        wr_en,
  output logic [7:0]  din,
  output logic        busy
);
  logic [63:0] shreg;
  logic [3:0]  left;

  assign busy  = (left != 4'd0);
  assign wr_en = busy && !full;
  assign din   = wr_en ? shreg[7:0] : 8'h00;

  // Load a fresh vector, or retire one byte each cycle the FIFO accepts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      left  <= '0;
    end else if (load) begin
      shreg <= vec;
      left  <= cnt;
    end else if (wr_en) begin
      shreg <= {8'h00, shreg[63:8]};
      left  <= left - 4'd1;
    end
  end
endmodule

// File: rtl/remote_mem.sv
// rtl/remote_mem.sv - TileLink slave forwarding Get/Put over byte FIFOs; Put forwarding under REMOTE_MEM_PUT_EN
`include "isa.vh"
module remote_mem #(
  parameter int ADDR_BYTES = 8,
  parameter int DATA_BYTES = 8,
  parameter int SOURCE_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  remote_mem_if.slave bus,
  input  logic        full,
  output logic        wr_en,
  output logic [7:0]  din,
  input  logic        empty,
  output logic        rd_en,
  input  logic [7:0]  dout
);
  import remote_mem_pkg::*;

  localparam int         DW       = DATA_BYTES * 8;
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

  state_t              state, state_nx;
  kind_t               kind_q, req_kind;
  logic [2:0]          eff_size, size_q, opc_q, k_q;
  logic [63:0]         addr_q;
  logic [SOURCE_W-1:0] src_q;
  logic [3:0]          need_q;
  logic [DW-1:0]       rdata_q;
  logic                accept, ser_load, ser_busy;
  logic [63:0]         ser_vec;
  logic [3:0]          ser_cnt;
  logic [7:0]          hdr_op;
`ifdef REMOTE_MEM_PUT_EN
  logic [DW-1:0]       wdata_q;
  wire unused_ok = &{1'b0, bus.a_mask};
`else
  wire unused_ok = &{1'b0, bus.a_mask, bus.a_data};
`endif

  assign accept         = (state == IDLE) && bus.a_valid;
  assign eff_size       = (bus.a_size > MAX_SIZE) ? MAX_SIZE : bus.a_size;
  assign hdr_op         = (req_kind == KIND_PUT) ? RM_OP_PUT : RM_OP_GET;
  assign bus.a_ready    = (state == IDLE);
  assign bus.d_valid    = (state == ACK);
  assign bus.d_opcode   = opc_q;
  assign bus.d_size     = size_q;
  assign bus.d_source   = src_q;
  assign bus.d_data     = rdata_q;

  // Classify the incoming A opcode; Put is only forwarded when the Put path is built in.
  always_comb begin
    req_kind = KIND_BAD;
    if (bus.a_opcode == `TL_A_GET) req_kind = KIND_GET;
`ifdef REMOTE_MEM_PUT_EN
    else if (bus.a_opcode == `TL_A_PUT_FULL_DATA || bus.a_opcode == `TL_A_PUT_PARTIAL_DATA)
      req_kind = KIND_PUT;
`endif
  end

  remote_mem_ser u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (ser_load),
    .vec   (ser_vec),
    .cnt   (ser_cnt),
    .full  (full),
    .wr_en (wr_en),
    .din   (din),
    .busy  (ser_busy)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, serialiser loads for each frame section, and response pops.
  always_comb begin
    state_nx = state;
    ser_load = 1'b0;
    ser_vec  = '0;
    ser_cnt  = '0;
    rd_en    = 1'b0;
    case (state)
      IDLE: if (bus.a_valid) begin
        if (req_kind == KIND_BAD) state_nx = ACK;
        else begin
          ser_load = 1'b1;
          ser_vec  = {48'h0, 5'h0, eff_size, hdr_op};
          ser_cnt  = 4'd2;
          state_nx = CMD_HDR;
        end
      end
      CMD_HDR: if (!ser_busy) begin
        ser_load = 1'b1;
        ser_vec  = addr_q;
        ser_cnt  = 4'(ADDR_BYTES);
        state_nx = CMD_ADDR;
      end
      CMD_ADDR: if (!ser_busy) begin
`ifdef REMOTE_MEM_PUT_EN
        if (kind_q == KIND_PUT) begin
          ser_load = 1'b1;
          ser_vec  = 64'(wdata_q);
          ser_cnt  = size_bytes(size_q);
          state_nx = CMD_DATA;
        end else
`endif
        state_nx = RSP_READ;
      end
`ifdef REMOTE_MEM_PUT_EN
      CMD_DATA: if (!ser_busy) state_nx = RSP_READ;
`endif
      RSP_READ: if (!empty) begin
        rd_en    = 1'b1;
        state_nx = RSP_CAP;
      end
      RSP_CAP:  state_nx = (({1'b0, k_q} + 4'd1) >= need_q) ? ACK : RSP_READ;
      ACK:      if (bus.d_ready) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Latch the request on acceptance and gather response bytes into the D beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q  <= KIND_BAD;
      size_q  <= '0;
      opc_q   <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      need_q  <= '0;
      k_q     <= '0;
      rdata_q <= '0;
`ifdef REMOTE_MEM_PUT_EN
      wdata_q <= '0;
`endif
    end else begin
      if (accept) begin
        kind_q  <= req_kind;
        size_q  <= eff_size;
        opc_q   <= (req_kind == KIND_GET) ? `TL_D_ACCESS_ACK_DATA : `TL_D_ACCESS_ACK;
        addr_q  <= bus.a_address;
        src_q   <= bus.a_source;
        need_q  <= (req_kind == KIND_GET) ? size_bytes(eff_size) : 4'd1;
        k_q     <= '0;
        rdata_q <= '0;
`ifdef REMOTE_MEM_PUT_EN
        wdata_q <= bus.a_data;
`endif
      end
      if (state == RSP_CAP) begin
        k_q <= k_q + 3'd1;
        if (kind_q == KIND_GET) begin
          for (int i = 0; i < DATA_BYTES; i++)
            if (k_q == 3'(i)) rdata_q[i*8 +: 8] <= dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_remote_mem.sv
// tb/tb_remote_mem.sv - randomized self-checking bench for remote_mem with FIFO models
module tb_remote_mem;
  localparam int AB = 8;
  localparam int DB = 8;
  localparam int SW = 4;
  localparam logic [2:0] OP_GET = 3'd4, OP_PUTF = 3'd0, OP_PUTP = 3'd1;
  localparam logic [2:0] D_ACK = 3'd0, D_ACK_DATA = 3'd1;
`ifdef REMOTE_MEM_PUT_EN
  localparam bit PUT_FWD = 1'b1;
`else
  localparam bit PUT_FWD = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, full = 1'b0, empty = 1'b1, wr_en, rd_en;
  logic [7:0] din, dout = 8'h00, dout_nx = 8'h00;
  int checks = 0, errors = 0, viol = 0, pops = 0, full_mode = 0;
  bit hold_empty = 1'b0;
  int unsigned cyc = 0;
  logic [7:0] cmd_q[$], rsp_q[$], exp_q[$];

  remote_mem_if #(.DATA_BYTES(DB), .SOURCE_W(SW)) bus();

  remote_mem #(.ADDR_BYTES(AB), .DATA_BYTES(DB), .SOURCE_W(SW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .full(full), .wr_en(wr_en), .din(din),
    .empty(empty), .rd_en(rd_en), .dout(dout)
  );

  always #5 clk = ~clk;

  // FIFO models: record pushes, serve pops, flag protocol violations.
  always @(posedge clk) begin
    if (!rst) begin
      if (wr_en) begin cmd_q.push_back(din); if (full) viol++; end
      if (rd_en) begin
        pops++;
        if (empty || rsp_q.size() == 0) viol++;
        else dout_nx = rsp_q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    case (full_mode)
      1: full = cyc[0];
      2: full = 1'($urandom_range(0, 1));
      default: full = 1'b0;
    endcase
    empty = hold_empty || (rsp_q.size() == 0);
    dout  = dout_nx;
  end

  // Reference frame: opcode, size, ADDR_BYTES address bytes, then N data bytes for a forwarded Put.
  function automatic void build_exp(input bit is_put, input bit is_get, input logic [2:0] esz,
                                     input logic [63:0] addr, input logic [63:0] data);
    exp_q.delete();
    if (!is_put && !is_get) return;
    exp_q.push_back(is_put ? 8'h01 : 8'h00);
    exp_q.push_back({5'd0, esz});
    for (int i = 0; i < AB; i++) exp_q.push_back(addr[8*i +: 8]);
    if (is_put) for (int i = 0; i < (1 << esz); i++) exp_q.push_back(data[8*i +: 8]);
  endfunction

  function automatic bit cmd_ok();
    if (cmd_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (cmd_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2:0] clamp(input logic [2:0] sz);
    return (int'(sz) > $clog2(DB)) ? 3'($clog2(DB)) : sz;
  endfunction

  task automatic send_req(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                          input logic [63:0] addr, input logic [63:0] data, output bit ok);
    int n = 0;
    @(negedge clk);
    bus.a_opcode = op; bus.a_size = sz; bus.a_source = src;
    bus.a_address = addr; bus.a_data = data; bus.a_mask = '1; bus.a_valid = 1'b1;
    while (bus.a_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    ok = (bus.a_ready === 1'b1);
    @(negedge clk);
    bus.a_valid = 1'b0;
  endtask

  task automatic collect_ack(input int hold, output bit got, output bit stable, output bit rel,
                             output logic [63:0] d, output logic [2:0] o, output logic [2:0] s,
                             output logic [3:0] src);
    int n = 0;
    got = 0; stable = 1; rel = 0; d = '0; o = '0; s = '0; src = '0;
    while (bus.d_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (bus.d_valid !== 1'b1) return;
    got = 1; d = bus.d_data; o = bus.d_opcode; s = bus.d_size; src = bus.d_source;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.d_valid !== 1'b1 || bus.d_data !== d || bus.d_opcode !== o || bus.a_ready !== 1'b0)
        stable = 0;
    end
    bus.d_ready = 1'b1;
    @(negedge clk);
    bus.d_ready = 1'b0;
    rel = (bus.d_valid === 1'b0) && (bus.a_ready === 1'b1);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({wr_en, rd_en, bus.d_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b want 000", {wr_en, rd_en, bus.d_valid}); end
    checks++; if (bus.d_data !== '0 || din !== 8'h00) begin errors++; $display("FAIL reset_data: got d_data=%h din=%h want 0", bus.d_data, din); end
    checks++; if ({bus.d_opcode, bus.d_size, bus.d_source} !== '0) begin errors++; $display("FAIL reset_dfields: got %h want 0", {bus.d_opcode, bus.d_size, bus.d_source}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b want 1", bus.a_ready); end
  endtask

  task automatic test_get_basic();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    logic [63:0] addr = 64'hEFCD_AB89_6745_2301;
    cmd_q.delete(); pops = 0;
    for (int i = 0; i < 8; i++) rsp_q.push_back(8'(8'h11 * (i + 1)));
    build_exp(1'b0, 1'b1, 3'd3, addr, '0);
    send_req(OP_GET, 3'd3, 4'h5, addr, '0, ok);
    collect_ack(0, got, stable, rel, d, o, s, src);
    checks++; if (!(ok && got)) begin errors++; $display("FAIL get_handshake: got ok=%b ack=%b want 1,1", ok, got); end
    checks++; if (d !== 64'h8877_6655_4433_2211) begin errors++; $display("FAIL get_data: got %h want 8877665544332211", d); end
    checks++; if (o !== D_ACK_DATA || s !== 3'd3 || src !== 4'h5) begin errors++; $display("FAIL get_fields: got op=%0d size=%0d src=%0d want 1,3,5", o, s, src); end
    checks++; if (!cmd_ok()) begin errors++; $display("FAIL get_din_stream: got %0d bytes want %0d matching bytes", cmd_q.size(), exp_q.size()); end
    checks++; if (!rel) begin errors++; $display("FAIL get_release: got no return to idle want idle"); end
  endtask

  task automatic test_put();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    cmd_q.delete(); pops = 0;
    if (PUT_FWD) rsp_q.push_back(8'h00);
    build_exp(PUT_FWD, 1'b0, 3'd2, 64'h1000, 64'hDEAD_BEEF);
    send_req(OP_PUTF, 3'd2, 4'h9, 64'h1000, 64'hDEAD_BEEF, ok);
    collect_ack(0, got, stable, rel, d, o, s, src);
    checks++; if (!(ok && got)) begin errors++; $display("FAIL put_handshake: got ok=%b ack=%b want 1,1", ok, got); end
    checks++; if (o !== D_ACK || s !== 3'd2 || src !== 4'h9 || d !== '0) begin errors++; $display("FAIL put_fields: got op=%0d size=%0d src=%0d data=%h want 0,2,9,0", o, s, src, d); end
    checks++; if (!cmd_ok()) begin errors++; $display("FAIL put_din_stream: got %0d bytes want %0d matching bytes", cmd_q.size(), exp_q.size()); end
    checks++; if (pops !== (PUT_FWD ? 1 : 0)) begin errors++; $display("FAIL put_pops: got %0d want %0d", pops, PUT_FWD ? 1 : 0); end
  endtask

  task automatic test_unsupported();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    cmd_q.delete(); pops = 0;
    send_req(3'd2, 3'd1, 4'h3, 64'h55, 64'h1234, ok);
    collect_ack(0, got, stable, rel, d, o, s, src);
    checks++; if (!(ok && got) || o !== D_ACK || s !== 3'd1 || src !== 4'h3) begin errors++; $display("FAIL bad_op_ack: got ack=%b op=%0d size=%0d src=%0d want 1,0,1,3", got, o, s, src); end
    checks++; if (cmd_q.size() != 0 || pops != 0) begin errors++; $display("FAIL bad_op_traffic: got %0d pushes %0d pops want 0,0", cmd_q.size(), pops); end
  endtask

  task automatic test_full_toggle();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    logic [63:0] addr = 64'hEFCD_AB89_6745_2301, exp_d = '0;
    cmd_q.delete(); pops = 0; full_mode = 1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b = 8'($urandom);
      rsp_q.push_back(b); exp_d |= 64'(b) << (8 * i);
    end
    build_exp(1'b0, 1'b1, 3'd3, addr, '0);
    send_req(OP_GET, 3'd3, 4'h1, addr, '0, ok);
    collect_ack(0, got, stable, rel, d, o, s, src);
    full_mode = 0;
    checks++; if (!cmd_ok()) begin errors++; $display("FAIL full_din_stream: got %0d bytes want %0d matching bytes", cmd_q.size(), exp_q.size()); end
    checks++; if (!got || d !== exp_d) begin errors++; $display("FAIL full_data: got %h want %h", d, exp_d); end
  endtask

  task automatic test_empty_stall();
    bit ok, got, stable, rel, quiet = 1; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    logic [63:0] addr = {$urandom, $urandom};
    int n = 0;
    cmd_q.delete(); pops = 0; hold_empty = 1;
    rsp_q.push_back(8'hA5);
    send_req(OP_GET, 3'd0, 4'h2, addr, '0, ok);
    while (cmd_q.size() < 2 + AB && n < 200) begin @(negedge clk); n++; end
    repeat (20) begin
      @(negedge clk);
      if (rd_en !== 1'b0 || bus.d_valid !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet || pops != 0) begin errors++; $display("FAIL stall_quiet: got quiet=%b pops=%0d want 1,0", quiet, pops); end
    hold_empty = 0;
    collect_ack(0, got, stable, rel, d, o, s, src);
    checks++; if (!got || d !== 64'hA5 || o !== D_ACK_DATA || s !== 3'd0) begin errors++; $display("FAIL stall_complete: got ack=%b data=%h op=%0d size=%0d want 1,a5,1,0", got, d, o, s); end
  endtask

  task automatic test_reset_mid();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    logic [63:0] exp_d = '0;
    int n = 0;
    cmd_q.delete(); pops = 0;
    send_req(OP_GET, 3'd3, 4'h7, {$urandom, $urandom}, '0, ok);
    while (cmd_q.size() < 4 && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1;
    #1;
    checks++; if (wr_en !== 1'b0 || rd_en !== 1'b0 || bus.d_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs: got wr=%b rd=%b dv=%b want 000", wr_en, rd_en, bus.d_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.a_ready !== 1'b1 || cmd_q.size() != 4 || pops != 0) begin errors++; $display("FAIL midrst_idle: got a_ready=%b pushes=%0d pops=%0d want 1,4,0", bus.a_ready, cmd_q.size(), pops); end
    cmd_q.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b = 8'($urandom);
      rsp_q.push_back(b); exp_d |= 64'(b) << (8 * i);
    end
    build_exp(1'b0, 1'b1, 3'd3, 64'h0123_4567_89AB_CDEF, '0);
    send_req(OP_GET, 3'd3, 4'h4, 64'h0123_4567_89AB_CDEF, '0, ok);
    collect_ack(0, got, stable, rel, d, o, s, src);
    checks++; if (!cmd_ok() || !got || d !== exp_d) begin errors++; $display("FAIL midrst_next_get: got data=%h bytes=%0d want %h,%0d", d, cmd_q.size(), exp_d, exp_q.size()); end
  endtask

  task automatic test_ack_hold();
    bit ok, got, stable, rel; logic [63:0] d; logic [2:0] o, s; logic [3:0] src;
    cmd_q.delete(); pops = 0;
    rsp_q.push_back(8'h3C); rsp_q.push_back(8'hC3);
    send_req(OP_GET, 3'd1, 4'h6, 64'h42, '0, ok);
    collect_ack(5, got, stable, rel, d, o, s, src);
    checks++; if (!got || !stable) begin errors++; $display("FAIL ack_hold_stable: got ack=%b stable=%b want 1,1", got, stable); end
    checks++; if (d !== 64'hC33C || !rel) begin errors++; $display("FAIL ack_hold_data: got %h release=%b want c33c,1", d, rel); end
  endtask

  task automatic test_random();
    logic [2:0] bad_ops[5] = '{3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
    for (int t = 0; t < 30; t++) begin
      bit ok, got, stable, rel, is_get, is_put;
      logic [63:0] d, addr, data, exp_d;
      logic [2:0] o, s, op, sz, esz;
      logic [3:0] src, rsrc;
      int r, nrsp;
      r = $urandom_range(0, 3);
      op = (r < 2) ? OP_GET : (r == 2) ? ($urandom_range(0, 1) ? OP_PUTP : OP_PUTF) : bad_ops[$urandom_range(0, 4)];
      sz = 3'($urandom_range(0, 7)); rsrc = 4'($urandom);
      addr = {$urandom, $urandom}; data = {$urandom, $urandom};
      esz = clamp(sz);
      is_get = (op == OP_GET);
      is_put = PUT_FWD && (op == OP_PUTF || op == OP_PUTP);
      nrsp = is_get ? (1 << esz) : (is_put ? 1 : 0);
      exp_d = '0;
      cmd_q.delete(); pops = 0; full_mode = 2;
      for (int i = 0; i < nrsp; i++) begin
        logic [7:0] b = 8'($urandom);
        rsp_q.push_back(b);
        if (is_get) exp_d |= 64'(b) << (8 * i);
      end
      build_exp(is_put, is_get, esz, addr, data);
      send_req(op, sz, rsrc, addr, data, ok);
      collect_ack(0, got, stable, rel, d, o, s, src);
      checks++; if (!(ok && got && rel)) begin errors++; $display("FAIL rnd%0d_handshake: got ok=%b ack=%b rel=%b want 1,1,1", t, ok, got, rel); end
      checks++; if (d !== exp_d) begin errors++; $display("FAIL rnd%0d_data: got %h want %h", t, d, exp_d); end
      checks++; if (o !== (is_get ? D_ACK_DATA : D_ACK) || s !== esz || src !== rsrc) begin errors++; $display("FAIL rnd%0d_fields: got op=%0d size=%0d src=%0d want %0d,%0d,%0d", t, o, s, src, is_get ? D_ACK_DATA : D_ACK, esz, rsrc); end
      checks++; if (!cmd_ok()) begin errors++; $display("FAIL rnd%0d_din_stream: got %0d bytes want %0d matching bytes", t, cmd_q.size(), exp_q.size()); end
      checks++; if (pops != nrsp || rsp_q.size() != 0) begin errors++; $display("FAIL rnd%0d_pops: got %0d left %0d want %0d,0", t, pops, rsp_q.size(), nrsp); end
    end
    full_mode = 0;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_opcode = '0; bus.a_size = '0; bus.a_source = '0;
    bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.d_ready = 0;
    test_reset();
    test_get_basic();
    test_put();
    test_unsupported();
    test_full_toggle();
    test_empty_stall();
    test_reset_mid();
    test_ack_hold();
    test_random();
    checks++; if (viol != 0) begin errors++; $display("FAIL fifo_protocol: got %0d violations want 0", viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/remote_mem.md
REMOTE_MEM -- requirements
Module: remote_mem

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 8, address bytes serialised per request (1..8).
REQ-002 SHALL have parameter DATA_BYTES, default 8, max beat width in bytes (power of two, 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bus  tilelink slave  -  A/D channels (a_valid/a_ready/a_opcode/a_size/a_source/a_address/a_mask/a_data; d_valid/d_ready/d_opcode/d_size/d_source/d_data).
REQ-006 SHALL have port full  input  1  command FIFO full.
REQ-007 SHALL have port wr_en  output  1  command FIFO push.
REQ-008 SHALL have port din  output  8  command FIFO byte.
REQ-009 SHALL have port empty  input  1  response FIFO empty.
REQ-010 SHALL have port rd_en  output  1  response FIFO pop.
REQ-011 SHALL have port dout  input  8  response FIFO byte, valid the cycle after rd_en.

Function
REQ-012 SHALL use states IDLE, CMD_HDR, CMD_ADDR, CMD_DATA, RSP_READ, RSP_CAP, ACK.
REQ-013 IDLE: a_ready=1; on a_valid&a_ready, latch opcode/size/source/address/data, go to CMD_HDR; a_ready=0 in all other states.
REQ-014 Effective size SHALL be min(a_size, log2(DATA_BYTES)); N = 1<<size bytes.
REQ-015 CMD_HDR: push opcode byte (RM_OP_GET=8'h00, RM_OP_PUT=8'h01), then size byte; CMD_ADDR: push ADDR_BYTES address bytes, LSB first.
REQ-016 CMD_DATA (Put only): push N bytes of a_data, LSB first; Get skips to RSP_READ.
REQ-017 wr_en SHALL assert only when full=0; din valid in same cycle; full=1 stalls with no byte lost or duplicated.
REQ-018 RSP_READ: assert rd_en for one cycle when empty=0; RSP_CAP: capture dout next cycle into byte slot k (first byte -> d_data[7:0]); loop until N bytes (Get) or 1 status byte (Put).
REQ-019 rd_en SHALL never assert while empty=1; at most one rd_en per two cycles.
REQ-020 ACK: d_valid=1, d_opcode=TL_ACCESS_ACK_DATA (Get) or TL_ACCESS_ACK (Put), d_size=size, d_source=latched a_source; held stable until d_ready.
REQ-021 On d_valid&d_ready return to IDLE; next request accepted no earlier than the following cycle.
REQ-022 Unused d_data bytes above N SHALL be zero; Put status byte ignored except completing the handshake.
REQ-023 Unsupported A opcodes SHALL be acknowledged with TL_ACCESS_ACK, no FIFO traffic.

Reset
REQ-024 rst SHALL force IDLE asynchronously; wr_en, din, rd_en, d_valid, d_data, d_opcode, d_size, d_source = 0; a_ready=1 after release.
REQ-025 Reset mid-transaction SHALL discard partial frame; no further wr_en/rd_en for that request.

Configuration
REQ-026 Macro REMOTE_MEM_PUT_EN defined: Put forwarded per REQ-015/016/018.
REQ-027 Macro REMOTE_MEM_PUT_EN undefined: Put handled as REQ-023 (immediate TL_ACCESS_ACK, no FIFO traffic); CMD_DATA logic absent.

Structure
REQ-028 Package remote_mem_pkg SHALL hold state enum, RM_OP_GET/RM_OP_PUT, status byte constant RM_STS_OK=8'h00.
REQ-029 Sub-module remote_mem_ser SHALL implement the byte serialiser (load vector+count, shift LSB-first, advance on ~full).
REQ-030 TL opcode macros SHALL come from isa.vh.

Verification
REQ-031 Get addr 64'hEFCD_AB89_6745_2301 size 3, full=0 -> din 00,03,01,23,45,67,89,AB,CD,EF; resp bytes 11..88 -> d_data 64'h8877_6655_4433_2211, ACCESS_ACK_DATA.
REQ-032 Put addr 64'h1000 size 2 data 32'hDEAD_BEEF -> din 01,02,00,10,00x6,EF,BE,AD,DE; status 00 -> TL_ACCESS_ACK, d_size=2.
REQ-033 full toggles every other cycle during Get -> identical 10-byte din sequence, no duplicates.
REQ-034 empty=1 for 20 cycles in RSP_READ -> rd_en stays 0, d_valid stays 0; then completes normally.
REQ-035 rst asserted after 4 command bytes -> wr_en=0 immediately, IDLE, next Get 64'h0123_4567_89AB_CDEF completes correctly.
REQ-036 d_ready held 0 for 5 cycles in ACK -> d_valid, d_data stable; a_ready=0 throughout.
